// File: rtl/floo_axis_beat_serializer.sv
// Wide-to-narrow beat serializer for the transmit side of the AXI-stream NoC
// bridge. One wide beat (tdata ++ tuser) is held and emitted as NumSlices
// link-lane words, least significant slice first, tagged with first/last so
// the far-end deserializer can realign. A new wide beat is taken in the same
// cycle the previous beat's last slice handshakes, so there is no bubble.
//
// state | meaning
// IDLE  | no beat held, input is ready, out_valid_o low
// SEND  | holding a beat, presenting slice[cnt_q] on the output
module floo_axis_beat_serializer #(
    parameter int unsigned InWidth   = 144,
    parameter int unsigned OutWidth  = 32,
    localparam int unsigned NumSlices = (InWidth + OutWidth - 1) / OutWidth,
    localparam int unsigned CntWidth  = (NumSlices > 1) ? $clog2(NumSlices) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [InWidth-1:0]  in_data_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    output logic [OutWidth-1:0] out_data_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic                out_first_o,
    output logic                out_last_o,
    output logic [31:0]         words_sent_o
);

    localparam int unsigned ExtWidth = NumSlices * OutWidth;
    localparam logic [CntWidth-1:0] LastIdx = CntWidth'(NumSlices - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [InWidth-1:0]  data_q, data_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                valid_q, valid_d;
    logic [31:0]         words_q, words_d;

    logic                              is_last;
    logic [NumSlices-1:0][OutWidth-1:0] slices;

    // Zero-extended view of the held beat; pad bits of the top slice read as 0.
    assign slices  = ExtWidth'(data_q);
    assign is_last = (cnt_q == LastIdx);

    // Single-slice configuration needs no index mux; the register is the output.
    if (NumSlices == 1) begin : g_one_slice
        assign out_data_o = slices[0];
    end else begin : g_multi_slice
        assign out_data_o = slices[cnt_q];
    end

    assign out_valid_o  = valid_q;
    assign out_first_o  = (cnt_q == '0);
    assign out_last_o   = is_last;
    assign words_sent_o = words_q;

    // Ready depends only on state and out_ready_i, never on in_valid_i.
    assign in_ready_o = (state_q == IDLE) | ((state_q == SEND) & out_ready_i & is_last);

    // Next-state: load on accept, step the slice index on each slice handshake.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        words_d = words_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    data_d  = in_data_i;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_ready_i) begin
                    if (!is_last) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        words_d = words_q + 32'd1;
                        if (in_valid_i) begin
                            data_d = in_data_i;
                            cnt_d  = '0;
                        end else begin
                            valid_d = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any partially sent beat.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            words_q <= words_d;
        end
    end

    a_params_ok: assert property (@(posedge clk_i)
        (OutWidth > 0) && (InWidth >= OutWidth));

    a_out_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (out_valid_o && !out_ready_i) |=>
        (out_valid_o && $stable(out_data_o) && $stable(out_first_o) && $stable(out_last_o)));

endmodule

// File: tb/tb_floo_axis_beat_serializer.sv
// Bench for floo_axis_beat_serializer: a 40/16 instance (three slices, 8 pad
// bits) and a 32/32 single-slice instance, both checked every cycle against a
// queue-of-slices reference model plus literal expectations from hand traces.
module tb_floo_axis_beat_serializer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 40-bit beats, 16-bit slices
    logic [39:0] a_in;
    logic        a_iv, a_ir;
    logic [15:0] a_od;
    logic        a_ov, a_or, a_of, a_ol;
    logic [31:0] a_ws;

    // 32-bit beats, 32-bit slices
    logic [31:0] b_in;
    logic        b_iv, b_ir;
    logic [31:0] b_od;
    logic        b_ov, b_or, b_of, b_ol;
    logic [31:0] b_ws;

    floo_axis_beat_serializer #(.InWidth(40), .OutWidth(16)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .in_data_i(a_in), .in_valid_i(a_iv), .in_ready_o(a_ir),
        .out_data_o(a_od), .out_valid_o(a_ov), .out_ready_i(a_or),
        .out_first_o(a_of), .out_last_o(a_ol), .words_sent_o(a_ws)
    );

    floo_axis_beat_serializer #(.InWidth(32), .OutWidth(32)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .in_data_i(b_in), .in_valid_i(b_iv), .in_ready_o(b_ir),
        .out_data_o(b_od), .out_valid_o(b_ov), .out_ready_i(b_or),
        .out_first_o(b_of), .out_last_o(b_ol), .words_sent_o(b_ws)
    );

    typedef struct packed {
        logic [15:0] d;
        logic        f;
        logic        l;
    } sl_t;

    sl_t         qa[$];
    logic [31:0] qb[$];
    logic [31:0] wa, wb;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: each accepted beat becomes an ordered list of pending slices; the
    // head is what the link must see, and a word is done when its last pops.
    task automatic model_step();
        logic        exp_ir_a, exp_ir_b;
        logic [47:0] ext;
        sl_t         h;
        exp_ir_a = (qa.size() == 0) || (qa.size() == 1 && a_or);
        exp_ir_b = (qb.size() == 0) || (qb.size() == 1 && b_or);

        chk("a_valid", 64'(a_ov), 64'(qa.size() != 0));
        if (qa.size() != 0) begin
            chk("a_data", 64'(a_od), 64'(qa[0].d));
            chk("a_first", 64'(a_of), 64'(qa[0].f));
            chk("a_last", 64'(a_ol), 64'(qa[0].l));
        end
        chk("a_in_ready", 64'(a_ir), 64'(exp_ir_a));
        chk("a_words", 64'(a_ws), 64'(wa));

        chk("b_valid", 64'(b_ov), 64'(qb.size() != 0));
        if (qb.size() != 0) begin
            chk("b_data", 64'(b_od), 64'(qb[0]));
            chk("b_first", 64'(b_of), 64'(1'b1));
            chk("b_last", 64'(b_ol), 64'(1'b1));
        end
        chk("b_in_ready", 64'(b_ir), 64'(exp_ir_b));
        chk("b_words", 64'(b_ws), 64'(wb));

        if (rst) begin
            qa.delete();
            qb.delete();
            wa = 32'd0;
            wb = 32'd0;
        end else begin
            if (qa.size() != 0 && a_or) begin
                h = qa.pop_front();
                if (h.l) wa = wa + 32'd1;
            end
            if (a_iv && exp_ir_a) begin
                ext = {8'h00, a_in};
                for (int k = 0; k < 3; k++) begin
                    h.d = 16'(ext >> (16 * k));
                    h.f = (k == 0);
                    h.l = (k == 2);
                    qa.push_back(h);
                end
            end
            if (qb.size() != 0 && b_or) begin
                void'(qb.pop_front());
                wb = wb + 32'd1;
            end
            if (b_iv && exp_ir_b) qb.push_back(b_in);
        end
    endtask

    // One clock: compare at the falling edge, then return just after the rising edge.
    task automatic step();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst  = 1'b1;
        a_in = '0; a_iv = 1'b0; a_or = 1'b0;
        b_in = '0; b_iv = 1'b0; b_or = 1'b0;
        wa = 32'd0; wb = 32'd0;
        repeat (2) step();
        rst = 1'b0;
        chk("rst_a_valid", 64'(a_ov), 64'(1'b0));
        chk("rst_a_ready", 64'(a_ir), 64'(1'b1));
        chk("rst_a_words", 64'(a_ws), 64'd0);
        chk("rst_b_valid", 64'(b_ov), 64'(1'b0));

        // Single beat, full ready
        a_or = 1'b1;
        a_in = 40'hAB_CDEF_1234; a_iv = 1'b1;
        step();
        a_iv = 1'b0; a_in = {8'($urandom), $urandom};
        chk("single_s0", 64'(a_od), 64'h1234);
        chk("single_s0_first", 64'(a_of), 64'(1'b1));
        step();
        chk("single_s1", 64'(a_od), 64'hCDEF);
        step();
        chk("single_s2", 64'(a_od), 64'h00AB);
        chk("single_s2_last", 64'(a_ol), 64'(1'b1));
        step();
        chk("single_idle", 64'(a_ov), 64'(1'b0));
        chk("single_words", 64'(a_ws), 64'd1);

        // Back-to-back: valid held for the four accept edges, then drained
        for (int i = 0; i < 10; i++) begin
            a_in = {8'($urandom), $urandom}; a_iv = 1'b1;
            step();
        end
        a_iv = 1'b0;
        repeat (3) step();
        chk("b2b_words", 64'(a_ws), 64'd5);
        chk("b2b_idle", 64'(a_ov), 64'(1'b0));

        // Backpressure 1,0,0,1 during one beat
        a_in = {8'($urandom), $urandom}; a_iv = 1'b1;
        step();
        a_iv = 1'b0;
        for (int i = 0; i < 16; i++) begin
            a_or = (i % 4 == 0) || (i % 4 == 3);
            step();
        end
        chk("bp_words", 64'(a_ws), 64'd6);

        // Reset after slice 1 of 3 has been sent
        a_or = 1'b1;
        a_in = 40'h11_2222_3333; a_iv = 1'b1;
        step();
        a_iv = 1'b0;
        repeat (2) step();
        chk("pre_rst_slice2", 64'(a_od), 64'h0011);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", 64'(a_ov), 64'(1'b0));
        chk("mid_rst_words", 64'(a_ws), 64'd0);
        chk("mid_rst_ready", 64'(a_ir), 64'(1'b1));
        a_in = 40'h44_5555_6666; a_iv = 1'b1;
        step();
        a_iv = 1'b0;
        chk("post_rst_s0", 64'(a_od), 64'h6666);
        chk("post_rst_first", 64'(a_of), 64'(1'b1));
        repeat (4) step();

        // Degenerate single-slice instance: one beat per cycle, 1-cycle latency
        b_or = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b_in = $urandom; b_iv = 1'b1;
            step();
            chk("deg_data", 64'(b_od), 64'(b_in));
            chk("deg_first_last", 64'({b_of, b_ol}), 64'(2'b11));
        end
        b_iv = 1'b0;
        step();
        chk("deg_words", 64'(b_ws), 64'd8);

        // Random traffic on both instances
        for (int i = 0; i < 400; i++) begin
            a_in = {8'($urandom), $urandom};
            a_iv = 1'($urandom_range(0, 1));
            a_or = ($urandom_range(0, 3) != 0);
            b_in = $urandom;
            b_iv = 1'($urandom_range(0, 1));
            b_or = ($urandom_range(0, 3) != 0);
            step();
        end
        a_iv = 1'b0; b_iv = 1'b0; a_or = 1'b1; b_or = 1'b1;
        repeat (6) step();

        // Completed-beat counter wrap
        force dut_a.words_q = 32'hFFFF_FFFF;
        wa = 32'hFFFF_FFFF;
        step();
        release dut_a.words_q;
        step();
        chk("wrap_preload", 64'(a_ws), 64'hFFFF_FFFF);
        a_in = 40'h00_0000_BEEF; a_iv = 1'b1;
        step();
        a_iv = 1'b0;
        chk("wrap_s0", 64'(a_od), 64'hBEEF);
        repeat (3) step();
        chk("wrap_words", 64'(a_ws), 64'd0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
